// File: rtl/alu_issue.sv
// alu_issue: issue/retire stage wrapped around the CPU ALU.
//   Accepts decoded ALU instructions with a valid/ready handshake. It evaluates the
//   condition code against the current CC register and strobes the ALU. It records
//   in-flight destination tags in a small FIFO. It converts ALU results into
//   register-file writebacks and CC updates.
// Ports:
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   i_valid / o_ready             upstream instruction handshake
//   i_op, i_a, i_b                opcode and operands (forwarded to the ALU)
//   i_dreg, i_wreg, i_wflags      destination index, writes-register, updates-CC
//   i_cond                        condition code selector
//   o_alu_stb, o_alu_op/a/b       ALU issue strobe and operands
//   i_alu_valid, i_alu_c, i_alu_f ALU result, flags {V,N,C,Z}
//   i_alu_busy                    ALU multi-cycle operation in progress
//   o_wb_stb, o_wb_reg, o_wb_data register-file writeback
//   o_flags                       CC register {V,N,C,Z}
//   o_idle                        nothing in flight and no writeback pending
//   o_err                         sticky: ALU result arrived with no tag in flight
module alu_issue #(
  parameter int TAG_DEPTH_LG = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_dreg,
  input  logic        i_wreg,
  input  logic        i_wflags,
  input  logic [2:0]  i_cond,
  output logic        o_alu_stb,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  input  logic        i_alu_valid,
  input  logic [31:0] i_alu_c,
  input  logic [3:0]  i_alu_f,
  input  logic        i_alu_busy,
  output logic        o_wb_stb,
  output logic [4:0]  o_wb_reg,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_flags,
  output logic        o_idle,
  output logic        o_err
);

  localparam int DEPTH = 1 << TAG_DEPTH_LG;
  localparam int PW    = TAG_DEPTH_LG + 1;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [4:0] dreg;
    logic       wreg;
    logic       wf;
  } tag_t;

  tag_t          tag_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fpend_q, fpend_d;
  logic [3:0]    flags_q, flags_d;
  logic          wb_stb_q, wb_stb_d;
  logic [4:0]    wb_reg_q, wb_reg_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          err_q, err_d;

  logic fifo_empty, fifo_full, cond_true, stall, accept, push, pop, push_wf;
  tag_t head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign head       = tag_q[rd_ptr_q[PW-2:0]];

  // Flag bit order {V,N,C,Z}: Z=0, C=1, N=2, V=3.
  always_comb begin
    cond_true = 1'b1;
    case (i_cond)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = flags_q[2];
      3'b010: cond_true = flags_q[0];
      3'b011: cond_true = !flags_q[0];
      3'b100: cond_true = !flags_q[0] && !flags_q[2];
      3'b101: cond_true = !flags_q[2];
      3'b110: cond_true = flags_q[1];
      3'b111: cond_true = flags_q[3];
      default: cond_true = 1'b1;
    endcase
  end

  // A conditional instruction must wait until every flag-writing instruction
  // ahead of it has retired, so that it sees the final CC value. Full uses the
  // registered pointers, so a same-cycle pop does not free a slot.
  assign stall   = i_alu_busy || fifo_full || ((i_cond != 3'b000) && (fpend_q != '0));
  assign o_ready = !stall;
  assign accept  = i_valid && o_ready;
  assign push    = accept && cond_true;
  assign push_wf = i_wflags && (i_cond == 3'b000);
  assign pop     = i_alu_valid && !fifo_empty;

  assign o_alu_stb = push;
  assign o_alu_op  = i_op;
  assign o_alu_a   = i_a;
  assign o_alu_b   = i_b;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fpend_d   = fpend_q;
    flags_d   = flags_q;
    wb_stb_d  = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ONE;
      wb_stb_d  = head.wreg;
      wb_reg_d  = head.dreg;
      wb_data_d = i_alu_c;
      if (head.wf) flags_d = i_alu_f;
    end
    if (i_alu_valid && fifo_empty) err_d = 1'b1;
    // Simultaneous increment and decrement cancel.
    case ({push && push_wf, pop && head.wf})
      2'b10:   fpend_d = fpend_q + ONE;
      2'b01:   fpend_d = fpend_q - ONE;
      default: fpend_d = fpend_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fpend_q   <= '0;
      flags_q   <= '0;
      wb_stb_q  <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fpend_q   <= fpend_d;
      flags_q   <= flags_d;
      wb_stb_q  <= wb_stb_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  // Tag storage carries data only; the pointers define which slots are live.
  always_ff @(posedge i_clk) begin
    if (push) tag_q[wr_ptr_q[PW-2:0]] <= '{dreg: i_dreg, wreg: i_wreg, wf: push_wf};
  end

  assign o_flags   = flags_q;
  assign o_wb_stb  = wb_stb_q;
  assign o_wb_reg  = wb_reg_q;
  assign o_wb_data = wb_data_q;
  assign o_idle    = fifo_empty && !wb_stb_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_op = '0;
  logic [31:0] i_a = '0, i_b = '0;
  logic [4:0]  i_dreg = '0;
  logic        i_wreg = 1'b0, i_wflags = 1'b0;
  logic [2:0]  i_cond = '0;
  logic        o_alu_stb;
  logic [3:0]  o_alu_op;
  logic [31:0] o_alu_a, o_alu_b;
  logic        i_alu_valid = 1'b0;
  logic [31:0] i_alu_c = '0;
  logic [3:0]  i_alu_f = '0;
  logic        i_alu_busy = 1'b0;
  logic        o_wb_stb;
  logic [4:0]  o_wb_reg;
  logic [31:0] o_wb_data;
  logic [3:0]  o_flags;
  logic        o_idle, o_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue #(.TAG_DEPTH_LG(1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_dreg(i_dreg), .i_wreg(i_wreg),
    .i_wflags(i_wflags), .i_cond(i_cond), .o_alu_stb(o_alu_stb), .o_alu_op(o_alu_op),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .i_alu_valid(i_alu_valid), .i_alu_c(i_alu_c),
    .i_alu_f(i_alu_f), .i_alu_busy(i_alu_busy), .o_wb_stb(o_wb_stb), .o_wb_reg(o_wb_reg),
    .o_wb_data(o_wb_data), .o_flags(o_flags), .o_idle(o_idle), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] dreg, input logic wreg,
                           input logic wflags, input logic [2:0] cond);
    i_valid = v; i_op = op; i_a = a; i_b = b; i_dreg = dreg;
    i_wreg = wreg; i_wflags = wflags; i_cond = cond;
  endtask

  task automatic set_alu(input logic v, input logic [31:0] c, input logic [3:0] f);
    i_alu_valid = v; i_alu_c = c; i_alu_f = f;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    #12;
    n_tests++; if (o_wb_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stb got %0b want 0", o_wb_stb); end
    n_tests++; if (o_wb_reg !== 5'd0 || o_wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb_regdata got %0d/%0d want 0/0", o_wb_reg, o_wb_data); end
    n_tests++; if (o_flags !== 4'd0) begin n_fail++; $display("FAIL reset_flags got %h want 0", o_flags); end
    n_tests++; if (o_idle !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL reset_idle_err got %0b/%0b want 1/0", o_idle, o_err); end
    n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", o_ready); end
    i_reset_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    set_instr(1'b1, 4'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 3'b000);
    #1;
    n_tests++; if (o_ready !== 1'b1 || o_alu_stb !== 1'b1) begin n_fail++; $display("FAIL add_issue ready/stb got %0b/%0b want 1/1", o_ready, o_alu_stb); end
    n_tests++; if (o_alu_op !== 4'd2 || o_alu_a !== 32'd5 || o_alu_b !== 32'd7) begin n_fail++; $display("FAIL add_fwd got %0d/%0d/%0d want 2/5/7", o_alu_op, o_alu_a, o_alu_b); end
    step();
    i_valid = 1'b0;
    set_alu(1'b1, 32'd12, 4'b0000);
    #1;
    n_tests++; if (o_wb_stb !== 1'b0 || o_idle !== 1'b0) begin n_fail++; $display("FAIL add_inflight stb/idle got %0b/%0b want 0/0", o_wb_stb, o_idle); end
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd3 || o_wb_data !== 32'd12) begin n_fail++; $display("FAIL add_wb got %0b/%0d/%0d want 1/3/12", o_wb_stb, o_wb_reg, o_wb_data); end
    n_tests++; if (o_flags !== 4'd0) begin n_fail++; $display("FAIL add_flags got %h want 0", o_flags); end
    step();
    n_tests++; if (o_wb_stb !== 1'b0 || o_idle !== 1'b1 || o_wb_data !== 32'd12) begin n_fail++; $display("FAIL add_after stb/idle/data got %0b/%0b/%0d want 0/1/12", o_wb_stb, o_idle, o_wb_data); end
  endtask

  task automatic test_cond_hold();
    set_instr(1'b1, 4'd3, 32'd1, 32'd1, 5'd1, 1'b1, 1'b1, 3'b000);
    #1;
    n_tests++; if (o_alu_stb !== 1'b1) begin n_fail++; $display("FAIL sub_issue stb got %0b want 1", o_alu_stb); end
    step();
    set_instr(1'b1, 4'd13, 32'd0, 32'd9, 5'd4, 1'b1, 1'b0, 3'b010);
    set_alu(1'b1, 32'd0, 4'b0001);
    #1;
    n_tests++; if (o_ready !== 1'b0 || o_alu_stb !== 1'b0) begin n_fail++; $display("FAIL bz_held ready/stb got %0b/%0b want 0/0", o_ready, o_alu_stb); end
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    #1;
    n_tests++; if (o_flags !== 4'b0001) begin n_fail++; $display("FAIL sub_flags got %h want 1", o_flags); end
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd1 || o_wb_data !== 32'd0) begin n_fail++; $display("FAIL sub_wb got %0b/%0d/%0d want 1/1/0", o_wb_stb, o_wb_reg, o_wb_data); end
    n_tests++; if (o_ready !== 1'b1 || o_alu_stb !== 1'b1) begin n_fail++; $display("FAIL bz_issue ready/stb got %0b/%0b want 1/1", o_ready, o_alu_stb); end
    step();
    i_valid = 1'b0;
    set_alu(1'b1, 32'd9, 4'b0000);
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd4 || o_wb_data !== 32'd9) begin n_fail++; $display("FAIL bz_wb got %0b/%0d/%0d want 1/4/9", o_wb_stb, o_wb_reg, o_wb_data); end
    n_tests++; if (o_flags !== 4'b0001) begin n_fail++; $display("FAIL bz_flags_kept got %h want 1", o_flags); end
  endtask

  task automatic test_cond_false();
    set_instr(1'b1, 4'd13, 32'd0, 32'd77, 5'd5, 1'b1, 1'b1, 3'b011);
    #1;
    n_tests++; if (o_ready !== 1'b1 || o_alu_stb !== 1'b0) begin n_fail++; $display("FAIL nz_skip ready/stb got %0b/%0b want 1/0", o_ready, o_alu_stb); end
    step();
    i_valid = 1'b0;
    n_tests++; if (o_idle !== 1'b1 || o_flags !== 4'b0001) begin n_fail++; $display("FAIL nz_state idle/flags got %0b/%h want 1/1", o_idle, o_flags); end
    step();
    n_tests++; if (o_wb_stb !== 1'b0 || o_wb_data !== 32'd9) begin n_fail++; $display("FAIL nz_no_wb stb/data got %0b/%0d want 0/9", o_wb_stb, o_wb_data); end
  endtask

  task automatic test_busy();
    set_instr(1'b1, 4'd12, 32'd3, 32'd4, 5'd6, 1'b1, 1'b0, 3'b000);
    #1;
    n_tests++; if (o_alu_stb !== 1'b1) begin n_fail++; $display("FAIL mpy_issue stb got %0b want 1", o_alu_stb); end
    step();
    i_alu_busy = 1'b1;
    set_instr(1'b1, 4'd2, 32'd1, 32'd1, 5'd7, 1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (o_ready !== 1'b0 || o_alu_stb !== 1'b0) begin n_fail++; $display("FAIL busy_held cyc%0d ready/stb got %0b/%0b want 0/0", k, o_ready, o_alu_stb); end
      step();
    end
    i_alu_busy = 1'b0;
    set_alu(1'b1, 32'd12, 4'b0000);
    #1;
    n_tests++; if (o_ready !== 1'b1 || o_alu_stb !== 1'b1) begin n_fail++; $display("FAIL busy_release ready/stb got %0b/%0b want 1/1", o_ready, o_alu_stb); end
    step();
    i_valid = 1'b0;
    set_alu(1'b1, 32'd2, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd6 || o_wb_data !== 32'd12) begin n_fail++; $display("FAIL mpy_wb got %0b/%0d/%0d want 1/6/12", o_wb_stb, o_wb_reg, o_wb_data); end
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd7 || o_wb_data !== 32'd2) begin n_fail++; $display("FAIL add2_wb got %0b/%0d/%0d want 1/7/2", o_wb_stb, o_wb_reg, o_wb_data); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_instr(1'b1, 4'd2, i, 32'd100, 5'(i + 8), 1'b1, 1'b0, 3'b000);
      else       i_valid = 1'b0;
      if (i >= 1 && i <= 8) set_alu(1'b1, 32'(i - 1 + 100), 4'b0000);
      else                  set_alu(1'b0, 32'd0, 4'b0000);
      #1;
      if (i < 8) begin
        n_tests++; if (o_ready !== 1'b1 || o_alu_stb !== 1'b1) begin n_fail++; $display("FAIL b2b_issue%0d ready/stb got %0b/%0b want 1/1", i, o_ready, o_alu_stb); end
      end
      step();
      if (i >= 1 && i <= 8) begin
        n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'(i - 1 + 8) || o_wb_data !== 32'(i - 1 + 100)) begin n_fail++; $display("FAIL b2b_wb%0d got %0b/%0d/%0d want 1/%0d/%0d", i - 1, o_wb_stb, o_wb_reg, o_wb_data, i - 1 + 8, i - 1 + 100); end
      end
    end
    set_alu(1'b0, 32'd0, 4'b0000);
    step();
    n_tests++; if (o_idle !== 1'b1 || o_wb_stb !== 1'b0) begin n_fail++; $display("FAIL b2b_idle idle/stb got %0b/%0b want 1/0", o_idle, o_wb_stb); end
  endtask

  task automatic test_full();
    set_instr(1'b1, 4'd2, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0, 3'b000);
    step();
    i_dreg = 5'd11;
    step();
    i_dreg = 5'd12;
    set_alu(1'b1, 32'd50, 4'b0000);
    #1;
    n_tests++; if (o_ready !== 1'b0 || o_alu_stb !== 1'b0) begin n_fail++; $display("FAIL full_pop_blocks ready/stb got %0b/%0b want 0/0", o_ready, o_alu_stb); end
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    #1;
    n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed ready got %0b want 1", o_ready); end
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd10 || o_wb_data !== 32'd50) begin n_fail++; $display("FAIL full_wb0 got %0b/%0d/%0d want 1/10/50", o_wb_stb, o_wb_reg, o_wb_data); end
    step();
    i_valid = 1'b0;
    set_alu(1'b1, 32'd51, 4'b0000);
    step();
    set_alu(1'b1, 32'd52, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd11 || o_wb_data !== 32'd51) begin n_fail++; $display("FAIL full_wb1 got %0b/%0d/%0d want 1/11/51", o_wb_stb, o_wb_reg, o_wb_data); end
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b1 || o_wb_reg !== 5'd12 || o_wb_data !== 32'd52) begin n_fail++; $display("FAIL full_wb2 got %0b/%0d/%0d want 1/12/52", o_wb_stb, o_wb_reg, o_wb_data); end
    n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL full_no_err got %0b want 0", o_err); end
    step();
  endtask

  task automatic test_reset_inflight();
    set_instr(1'b1, 4'd3, 32'd9, 32'd9, 5'd2, 1'b1, 1'b1, 3'b000);
    step();
    i_valid = 1'b0;
    #2;
    i_reset_n = 1'b0;
    #1;
    n_tests++; if (o_idle !== 1'b1 || o_flags !== 4'd0) begin n_fail++; $display("FAIL rst_async idle/flags got %0b/%h want 1/0", o_idle, o_flags); end
    #2;
    i_reset_n = 1'b1;
    step();
    set_alu(1'b1, 32'd0, 4'b0101);
    step();
    set_alu(1'b0, 32'd0, 4'b0000);
    n_tests++; if (o_wb_stb !== 1'b0) begin n_fail++; $display("FAIL rst_orphan_wb got %0b want 0", o_wb_stb); end
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL rst_orphan_err got %0b want 1", o_err); end
    n_tests++; if (o_flags !== 4'd0) begin n_fail++; $display("FAIL rst_orphan_flags got %h want 0", o_flags); end
    step();
    n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b want 1", o_err); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cond_hold();
    test_cond_false();
    test_busy();
    test_back_to_back();
    test_full();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
